// File: rtl/imem_boot_loader.sv
// Instruction memory for the single-cycle MIPS core, filled at boot from a
// big-endian byte stream (length, data words, XOR checksum); holds the core in reset until loaded.
module imem_boot_loader #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [31:0] inst_adr,
  output logic [31:0] inst,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [7:0]          csum_q, csum_d;
  logic [23:0]         asm_q, asm_d;
  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic [ADDR_W-1:0]   rd_word;
  logic                rd_hit;
  logic                unused_adr_bits;

  assign rx_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept    = rx_valid && rx_ready;
  assign cpu_rst   = (state_q != S_RUN);
  assign load_done = (state_q == S_RUN);
  assign load_err  = (state_q == S_ERROR);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    mem_we     = 1'b0;
    mem_wdata  = {asm_q, rx_data};
    if (accept) begin
      case (state_q)
        S_LEN_HI: begin
          n_d     = {rx_data, n_q[7:0]};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          // Range decision uses the full 16-bit length including this byte.
          n_d = {n_q[15:8], rx_data};
          if (32'(n_d) > DEPTH)   state_d = S_ERROR;
          else if (n_d == 16'h0)  state_d = S_CSUM;
          else                    state_d = S_DATA;
        end
        S_DATA: begin
          csum_d     = csum_q ^ rx_data;
          asm_d      = {asm_q[15:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we     = 1'b1;
            word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            if (32'(word_cnt_d) == 32'(n_q)) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          state_d = (rx_data == csum_q) ? S_RUN : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN_HI;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      asm_q      <= asm_d;
    end
  end

  // Array deliberately outside reset: contents survive rst, gated by N on read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_cnt_q[ADDR_W-1:0]] <= mem_wdata;
  end

  assign rd_word         = inst_adr[ADDR_W+1:2];
  assign rd_hit          = (state_q == S_RUN) && (32'(rd_word) < 32'(n_q)) &&
                           (inst_adr[31:ADDR_W+2] == '0);
  assign inst            = rd_hit ? mem_q[rd_word] : 32'h0;
  assign unused_adr_bits = ^inst_adr[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, bad checksum, length bounds,
// empty program, gapped stream and reset mid-load.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] inst_adr;
  logic [31:0] inst;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned ready_drops = 0;

  imem_boot_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .inst_adr  (inst_adr),
    .inst      (inst),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Inputs change 1 time unit after the edge; rx_ready is sampled there as well.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    rx_valid = 1'b0;
    for (int unsigned g = 0; g < gap; g++) begin
      @(posedge clk);
      #1 if (rx_ready !== 1'b1) ready_drops++;
    end
    if (rx_ready !== 1'b1) ready_drops++;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--)
      send_byte(w[8*i +: 8], gaps ? $urandom_range(0, 5) : 0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    inst_adr = adr;
    #1 chk(tag, inst, exp);
  endtask

  function automatic logic [7:0] xor_bytes(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    x = a ^ b;
    return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
  endfunction

  localparam logic [31:0] W0 = 32'h20080005;
  localparam logic [31:0] W1 = 32'h2009000A;
  localparam logic [31:0] W6 = 32'h8C090004;

  task automatic load_two(input logic [7:0] cs, input bit gaps, input bit last_check);
    send_byte(8'h00, gaps ? $urandom_range(0, 5) : 0);
    send_byte(8'h02, gaps ? $urandom_range(0, 5) : 0);
    send_word(W0, gaps);
    send_word(W1, gaps);
    if (last_check) begin
      chk("pre_csum_done", {31'b0, load_done}, 32'd0);
      chk("pre_csum_cpurst", {31'b0, cpu_rst}, 32'd1);
    end
    send_byte(cs, gaps ? $urandom_range(0, 5) : 0);
  endtask

  logic [7:0] good_cs;

  initial begin
    inst_adr = 32'h0;
    good_cs  = xor_bytes(W0, W1);   // 0x0E
    do_reset();

    chk("rst_cpu_rst",   {31'b0, cpu_rst},   32'd1);
    chk("rst_rx_ready",  {31'b0, rx_ready},  32'd1);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_load_err",  {31'b0, load_err},  32'd0);
    read_chk("rst_inst0", 32'h0, 32'h0);

    // Two-word program, correct checksum
    load_two(good_cs, 1'b0, 1'b1);
    chk("t1_done",     {31'b0, load_done}, 32'd1);
    chk("t1_cpu_rst",  {31'b0, cpu_rst},   32'd0);
    chk("t1_err",      {31'b0, load_err},  32'd0);
    chk("t1_rx_ready", {31'b0, rx_ready},  32'd0);
    read_chk("t1_inst0",  32'h0,    W0);
    read_chk("t1_inst4",  32'h4,    W1);
    read_chk("t1_inst8",  32'h8,    32'h0);
    read_chk("t1_inst7",  32'h7,    W1);
    read_chk("t1_hiadr",  32'h1000, 32'h0);

    // Bad checksum
    do_reset();
    load_two(good_cs ^ 8'h01, 1'b0, 1'b0);
    chk("t2_err",      {31'b0, load_err},  32'd1);
    chk("t2_cpu_rst",  {31'b0, cpu_rst},   32'd1);
    chk("t2_rx_ready", {31'b0, rx_ready},  32'd0);
    chk("t2_done",     {31'b0, load_done}, 32'd0);
    read_chk("t2_inst0", 32'h0, 32'h0);
    read_chk("t2_inst4", 32'h4, 32'h0);
    send_byte(good_cs, 0);
    chk("t2_sticky", {31'b0, load_err}, 32'd1);

    // Length one above DEPTH rejected on LEN_LO edge
    do_reset();
    send_byte(8'h04, 0);
    chk("t3_mid_err", {31'b0, load_err}, 32'd0);
    send_byte(8'h01, 0);
    chk("t3_err",      {31'b0, load_err}, 32'd1);
    chk("t3_rx_ready", {31'b0, rx_ready}, 32'd0);

    // Length exactly DEPTH accepted
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    chk("t3b_err",   {31'b0, load_err}, 32'd0);
    chk("t3b_ready", {31'b0, rx_ready}, 32'd1);

    // Empty program
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("t4_pre_done", {31'b0, load_done}, 32'd0);
    send_byte(8'h00, 0);
    chk("t4_done", {31'b0, load_done}, 32'd1);
    chk("t4_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    read_chk("t4_inst0",   32'h0,   32'h0);
    read_chk("t4_inst100", 32'h100, 32'h0);

    // Gapped stream
    do_reset();
    ready_drops = 0;
    load_two(good_cs, 1'b1, 1'b0);
    chk("t5_ready_drops", ready_drops, 32'd0);
    chk("t5_done",    {31'b0, load_done}, 32'd1);
    chk("t5_err",     {31'b0, load_err},  32'd0);
    chk("t5_cpu_rst", {31'b0, cpu_rst},   32'd0);
    read_chk("t5_inst0", 32'h0, W0);
    read_chk("t5_inst4", 32'h4, W1);
    read_chk("t5_inst8", 32'h8, 32'h0);

    // Reset after five data bytes, then a one-word load
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 0);
    do_reset();
    chk("t6_rst_ready", {31'b0, rx_ready}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(W6, 1'b0);
    send_byte(xor_bytes(W6, 32'h0), 0);   // 0x81
    chk("t6_done", {31'b0, load_done}, 32'd1);
    chk("t6_err",  {31'b0, load_err},  32'd0);
    read_chk("t6_inst0", 32'h0, W6);
    read_chk("t6_inst4", 32'h4, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
